ram_arbiter: RTL

- Shares the core's single data-RAM port between two masters with a round-robin arbiter.
- Master 0 is the core mem stage (ram_req/ram_we/ram_addr/ram_wdata). Master 1 is a second bus master, e.g. a debug/DMA engine.
- Sits between coretop and the RAM. Sequences one outstanding transaction at a time against a variable-latency RAM with an ack handshake.
- Exports a per-master stall signal that drives the pipeline controller.

---
 rtl/ram_arbiter_pkg.sv | 13 +
 rtl/ram_arb_rr.sv | 39 +++
 rtl/ram_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-master data-RAM arbiter: FSM encoding and master ids.
package ram_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-requester round-robin grant; last_gnt remembers the previous winner so a tie goes to the other one.
module ram_arb_rr
    import ram_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt,
    output logic       winner
);

    logic last_gnt;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        winner = M0;
        gnt    = 2'b00;
        case (req)
            2'b01:   winner = M0;
            2'b10:   winner = M1;
            2'b11:   winner = ~last_gnt;
            default: winner = M0;
        endcase
        if (|req) begin
            gnt = (winner == M1) ? 2'b10 : 2'b01;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_gnt <= M1;
        end else if (update) begin
            last_gnt <= winner;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sharing of the single data-RAM port between the core mem stage (m0) and a second master (m1).
// Optional wait-for-ack timeout is compiled in with RAM_ARB_TIMEOUT_EN.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [XLEN-1:0] m0_addr_i,
    input  logic [XLEN-1:0] m0_wdata_i,
    output logic            m0_ack_o,
    output logic [XLEN-1:0] m0_rdata_o,
    output logic            m0_err_o,
    output logic            m0_stall_o,

    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [XLEN-1:0] m1_addr_i,
    input  logic [XLEN-1:0] m1_wdata_i,
    output logic            m1_ack_o,
    output logic [XLEN-1:0] m1_rdata_o,
    output logic            m1_err_o,
    output logic            m1_stall_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    if (2 ** CNT_W <= TIMEOUT_CYC) begin : g_cnt_w_check
        $error("CNT_W is too narrow to count to TIMEOUT_CYC");
    end

    logic [1:0]      state;
    logic            id_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            winner;
    logic            update;
    logic            in_wait;
    logic            in_resp;
    logic            sel_we;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt;
    logic             err_q;
`endif

    assign req     = {m1_req_i, m0_req_i};
    assign update  = (state == ST_IDLE) && (|req);
    assign in_wait = (state == ST_WAIT);
    assign in_resp = (state == ST_RESP);

    ram_arb_rr u_rr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    (req),
        .update (update),
        .gnt    (gnt),
        .winner (winner)
    );

    // One-hot grant steers the winning master's fields into the transaction registers.
    assign sel_we    = (gnt[0] & m0_we_i) | (gnt[1] & m1_we_i);
    assign sel_addr  = ({XLEN{gnt[0]}} & m0_addr_i)  | ({XLEN{gnt[1]}} & m1_addr_i);
    assign sel_wdata = ({XLEN{gnt[0]}} & m0_wdata_i) | ({XLEN{gnt[1]}} & m1_wdata_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            id_q    <= M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt     <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        id_q    <= winner;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        rdata_q <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
                        cnt     <= '0;
                        err_q   <= 1'b0;
`endif
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (mem_ack_i) begin
                        rdata_q <= we_q ? '0 : mem_rdata_i;
                        state   <= ST_RESP;
                    end
`ifdef RAM_ARB_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_o   = in_wait;
    assign mem_we_o    = in_wait & we_q;
    assign mem_addr_o  = in_wait ? addr_q  : '0;
    assign mem_wdata_o = in_wait ? wdata_q : '0;

    assign m0_ack_o   = in_resp && (id_q == M0);
    assign m1_ack_o   = in_resp && (id_q == M1);
    assign m0_rdata_o = m0_ack_o ? rdata_q : '0;
    assign m1_rdata_o = m1_ack_o ? rdata_q : '0;

`ifdef RAM_ARB_TIMEOUT_EN
    assign m0_err_o = m0_ack_o & err_q;
    assign m1_err_o = m1_ack_o & err_q;
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    assign m0_stall_o = m0_req_i & ~m0_ack_o;
    assign m1_stall_o = m1_req_i & ~m1_ack_o;

endmodule
